// File: rtl/seg_pkg.sv
// Shared definitions for the keypad scanner and the 7-segment display mux.
// Segment patterns are active-low: bit7 = dp, bits6..0 = a..g, 8'hFF = dark.
// Digit selects are active-low; bit k selects digit k, with k=0 the rightmost.
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t       SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam int         N_DIG     = 4;

  // Active-low one-hot select for digit `slot`.
  function automatic logic [3:0] an_select(input logic [1:0] slot);
    an_select = ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Bundle between the keypad scanner side and the display mux.
// Signals:
//   en         display enable (driver -> mux)
//   bright     4-bit brightness (driver -> mux)
//   dig1..dig4 segment patterns, dig1 = rightmost / newest key (driver -> mux)
//   seg        segment drive, active-low (mux -> display)
//   an         digit select, active-low (mux -> display)
//   frame_tick one-cycle pulse after each complete 4-slot frame (mux -> driver)
// Timing contract: there is no valid/ready handshake. The driver may change
// any input at any time. The mux samples en and bright on every rising clk
// edge, and it samples dig1..dig4 only at the first cycle of each frame. All
// outputs are registered.
interface seg_display_mux_if;
  import seg_pkg::*;

  logic       en;
  logic [3:0] bright;
  seg_t       dig1;
  seg_t       dig2;
  seg_t       dig3;
  seg_t       dig4;
  seg_t       seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output en, bright, dig1, dig2, dig3, dig4,
    input  seg, an, frame_tick
  );

  modport slave (
    input  en, bright, dig1, dig2, dig3, dig4,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg_slot_timer.sv
// Slot timer for the display mux.
// cnt counts 0..DIV-1 inside a digit slot. slot advances 0..3 each time cnt
// wraps. While en is low, both counters are parked at 0, so that the next
// enable starts a clean frame.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          run enable
//   cnt         cycle position inside the current slot
//   slot        current digit slot (0 = rightmost)
//   wrap        cnt is at DIV-1 while enabled (the slot ends this cycle)
//   frame_end   wrap in slot 3 (the frame ends this cycle)
//   snap        first cycle of a frame while enabled (the input snapshot point)
module seg_slot_timer #(
  parameter int DIV = 1000,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic [1:0]    slot,
  output logic          wrap,
  output logic          frame_end,
  output logic          snap
);

  assign wrap      = en && (cnt == CW'(DIV - 1));
  assign frame_end = wrap && (slot == 2'd3);
  assign snap      = en && (slot == 2'd0) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else if (!en) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else if (wrap) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexes four segment patterns onto one shared 4-digit
// common-anode display. The block blanks the display at the start of each
// slot to stop ghosting. It snapshots the inputs once per frame so that a
// frame never tears. It also applies 16-level brightness PWM inside the
// active window of each slot.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         seg_display_mux_if slave: en, bright, dig1..dig4 in;
//               seg, an, frame_tick out (all outputs registered)
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input logic               clk,
  input logic               rst_n,
  seg_display_mux_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic          wrap;
  logic          frame_end;
  logic          snap;

  seg_slot_timer #(.DIV(DIV), .CW(CW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.en),
    .cnt       (cnt),
    .slot      (slot),
    .wrap      (wrap),
    .frame_end (frame_end),
    .snap      (snap)
  );

  // Per-frame copy of the inputs. Changes on dig1..dig4 outside the snapshot
  // cycle stay hidden until the next frame begins.
  seg_t shadow [N_DIG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIG; i++) shadow[i] <= SEG_BLANK;
    end else if (snap) begin
      shadow[0] <= bus.dig1;
      shadow[1] <= bus.dig2;
      shadow[2] <= bus.dig3;
      shadow[3] <= bus.dig4;
    end
  end

  // PWM phase inside the active window. cnt >= BLANK holds wherever the
  // phase is used, so the subtraction never underflows. Only the low 4 bits
  // are kept, which makes long windows repeat the PWM every 16 cycles.
  logic       in_blank;
  logic [3:0] pwm_phase;
  logic       lit;

  assign in_blank  = (cnt < CW'(BLANK));
  assign pwm_phase = 4'(cnt - CW'(BLANK));
  assign lit       = bus.en && !in_blank && (pwm_phase <= bus.bright);

  seg_t       seg_next;
  logic [3:0] an_next;
  logic       tick_next;

  always_comb begin
    seg_next  = SEG_BLANK;
    an_next   = AN_OFF;
    tick_next = frame_end;
    if (lit) begin
      seg_next = shadow[slot];
      an_next  = an_select(slot);
    end
  end

  // All outputs have one cycle of latency. Blanking and the disable case
  // both fall out of `lit`, so at most one an bit is ever low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg        <= SEG_BLANK;
      bus.an         <= AN_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.seg        <= seg_next;
      bus.an         <= an_next;
      bus.frame_tick <= tick_next;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
module tb_seg_display_mux;
  import seg_pkg::*;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_mux_if bus ();

  seg_display_mux #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // The model tracks the position inside a 32-cycle frame as one integer. It
  // derives slot/offset from that position by division.
  int         pos;
  logic [7:0] m_shadow [4];
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_tick;
  int         exp_ticks;
  int         obs_ticks;

  // Scoreboard: one expected seg value is queued per modelled edge.
  logic [7:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [3:0] digit_sel(input int s);
    logic [3:0] tab [4];
    tab[0] = 4'b1110; tab[1] = 4'b1101; tab[2] = 4'b1011; tab[3] = 4'b0111;
    return tab[s];
  endfunction

  task automatic model_reset();
    pos = 0;
    for (int i = 0; i < 4; i++) m_shadow[i] = 8'hFF;
    exp_seg  = 8'hFF;
    exp_an   = 4'b1111;
    exp_tick = 1'b0;
  endtask

  task automatic model_edge();
    int s;
    int c;
    if (!rst_n) begin
      model_reset();
    end else if (!bus.en) begin
      pos      = 0;
      exp_seg  = 8'hFF;
      exp_an   = 4'b1111;
      exp_tick = 1'b0;
    end else begin
      s = pos / DIV;
      c = pos % DIV;
      if (pos == 0) begin
        m_shadow[0] = bus.dig1; m_shadow[1] = bus.dig2;
        m_shadow[2] = bus.dig3; m_shadow[3] = bus.dig4;
      end
      exp_seg = 8'hFF;
      exp_an  = 4'b1111;
      if (c >= BLANK && ((c - BLANK) % 16) <= int'(bus.bright)) begin
        exp_seg = m_shadow[s];
        exp_an  = digit_sel(s);
      end
      exp_tick = (pos == FRAME - 1);
      if (exp_tick) exp_ticks++;
      pos = (pos + 1) % FRAME;
    end
    exp_q.push_back(exp_seg);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // One clock: the model updates at the rising edge, and the DUT is checked
  // at the following falling edge.
  task automatic step();
    logic [7:0] q_seg;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    q_seg = exp_q.pop_front();
    chk("seg", bus.seg, q_seg);
    chk("an", {4'b0, bus.an}, {4'b0, exp_an});
    chk("tick", {7'b0, bus.frame_tick}, {7'b0, exp_tick});
    n_cmp++;
    assert ($countones(~bus.an) <= 1) else begin
      n_err++;
      $error("FAIL an_onehot: observed %b expected at most one low bit", bus.an);
    end
    if (bus.frame_tick === 1'b1) obs_ticks++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    exp_ticks  = 0;
    obs_ticks  = 0;
    model_reset();
    bus.en     = 1'b0;
    bus.bright = 4'd0;
    bus.dig1   = 8'h00; bus.dig2 = 8'h00; bus.dig3 = 8'h00; bus.dig4 = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_seg", bus.seg, 8'hFF);
    chk("rst_an", {4'b0, bus.an}, 8'h0F);
    chk("rst_tick", {7'b0, bus.frame_tick}, 8'h00);
    rst_n = 1'b1;

    // Basic multiplexing at full brightness
    bus.en = 1'b1; bus.bright = 4'd15;
    bus.dig1 = 8'h81; bus.dig2 = 8'hCF; bus.dig3 = 8'h92; bus.dig4 = 8'h86;
    run(2 * FRAME);

    // Input change mid-frame stays invisible until the next snapshot
    while ((pos / DIV) != 2) step();
    bus.dig1 = 8'hF2;
    run(FRAME + DIV);

    // Brightness levels
    bus.bright = 4'd0;
    run(FRAME);
    bus.bright = 4'd3;
    run(FRAME);
    bus.bright = 4'd15;

    // Enable dropped in slot 1, then raised 5 cycles later
    while (!((pos / DIV) == 1 && (pos % DIV) == 3)) step();
    bus.en = 1'b0;
    step();
    bus.dig2 = 8'hA4;
    run(4);
    bus.en = 1'b1;
    run(FRAME + 4);

    // Reset mid-run: the outputs must clear without a clock edge
    while (!((pos / DIV) == 2 && (pos % DIV) == 5)) step();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_seg", bus.seg, 8'hFF);
    chk("midrst_an", {4'b0, bus.an}, 8'h0F);
    chk("midrst_tick", {7'b0, bus.frame_tick}, 8'h00);
    run(2);
    rst_n = 1'b1;
    run(FRAME);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 9) == 0) bus.bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.dig1 = 8'($urandom);
          1: bus.dig2 = 8'($urandom);
          2: bus.dig3 = 8'($urandom);
          default: bus.dig4 = 8'($urandom);
        endcase
      end
      step();
    end
    bus.en = 1'b1;
    run(FRAME);

    chk("tick_count", 8'(obs_ticks), 8'(exp_ticks));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
